// File: rtl/hazard_control.sv
// ---------------------------------------------------------------------------
// hazard_control
//   Hazard detection and stall/flush control for the 5-stage MIPS pipeline.
//   Sits beside ID, upstream of the forwarding unit.
//   - Stalls IF/ID and PC, and bubbles ID/EX, on:
//       load-use hazards,
//       a branch that depends on a load now in MEM,
//       MDU busy conflicts.
//   - Flushes IF/ID on a taken branch when ID is not stalled.
//   - Tracks the multiply/divide unit with a 6-bit countdown.
//   - Keeps saturating stall and flush cycle counters.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   IF_ID_*                     decode info for the instruction in ID
//   branch_taken                ID comparator result (already gated by Branch)
//   ID_EX_rt / ID_EX_MemRead    load destination / load flag in EX
//   EX_MEM_rd / EX_MEM_MemRead  destination / load flag in MEM
//   PC_Write, IF_ID_Write       pipeline front-end enables
//   ID_EX_Flush                 insert bubble into ID/EX
//   IF_ID_Flush                 squash the fetched instruction
//   md_busy                     MDU countdown nonzero
//   stall_count, flush_count    saturating performance counters
// ---------------------------------------------------------------------------
module hazard_control #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_Branch,
    input  logic             IF_ID_MdStart,
    input  logic             IF_ID_MdIsDiv,
    input  logic             IF_ID_ReadsHiLo,
    input  logic             branch_taken,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_MemRead,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Flush,
    output logic             IF_ID_Flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [5:0] MULT_L = 6'(MULT_LAT);
    localparam logic [5:0] DIV_L  = 6'(DIV_LAT);

    logic [5:0]       r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_branch_load_mem;
    logic w_md_hazard;
    logic w_stall;
    logic w_flush;

    // Register $0 is hardwired to zero, so it never carries a dependency.
    assign w_load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                        ((ID_EX_rt == IF_ID_rs) ||
                         (IF_ID_UsesRt && (ID_EX_rt == IF_ID_rt)));

    // Branches compare in ID.
    // Load data still in MEM cannot be forwarded in time, so the branch waits.
    // ALU results in EX/MEM are covered by forwarding.
    assign w_branch_load_mem = IF_ID_Branch && EX_MEM_MemRead &&
                               (EX_MEM_rd != 5'd0) &&
                               ((EX_MEM_rd == IF_ID_rs) || (EX_MEM_rd == IF_ID_rt));

    assign md_busy     = (r_md_cnt != 6'd0);
    assign w_md_hazard = md_busy && (IF_ID_MdStart || IF_ID_ReadsHiLo);
    assign w_stall     = w_load_use || w_branch_load_mem || w_md_hazard;

    // A stalled branch has stale operands, so its taken signal is ignored.
    assign w_flush = !w_stall && branch_taken;

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Flush = 1'b0;
        IF_ID_Flush = 1'b0;
        // During reset the pipeline registers clear themselves.
        // Keep the front end enabled and the control outputs quiet.
        if (!reset) begin
            PC_Write    = !w_stall;
            IF_ID_Write = !w_stall;
            ID_EX_Flush = w_stall;
            IF_ID_Flush = w_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt    <= 6'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // MdStart is held off by md_hazard while busy.
            // A load therefore never clobbers a live count.
            if (IF_ID_MdStart && !w_stall)
                r_md_cnt <= IF_ID_MdIsDiv ? DIV_L : MULT_L;
            else if (r_md_cnt != 6'd0)
                r_md_cnt <= r_md_cnt - 6'd1;

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    localparam int CNT_W    = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       IF_ID_rs, IF_ID_rt, ID_EX_rt, EX_MEM_rd;
    logic             IF_ID_UsesRt, IF_ID_Branch, IF_ID_MdStart, IF_ID_MdIsDiv;
    logic             IF_ID_ReadsHiLo, branch_taken, ID_EX_MemRead, EX_MEM_MemRead;
    logic             PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles of MDU work left, and plain integer counters.
    int m_left = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    hazard_control #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .IF_ID_rs(IF_ID_rs),
        .IF_ID_rt(IF_ID_rt),
        .IF_ID_UsesRt(IF_ID_UsesRt),
        .IF_ID_Branch(IF_ID_Branch),
        .IF_ID_MdStart(IF_ID_MdStart),
        .IF_ID_MdIsDiv(IF_ID_MdIsDiv),
        .IF_ID_ReadsHiLo(IF_ID_ReadsHiLo),
        .branch_taken(branch_taken),
        .ID_EX_rt(ID_EX_rt),
        .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead),
        .PC_Write(PC_Write),
        .IF_ID_Write(IF_ID_Write),
        .ID_EX_Flush(ID_EX_Flush),
        .IF_ID_Flush(IF_ID_Flush),
        .md_busy(md_busy),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_stall();
        bit lu, bl, md;
        lu = ID_EX_MemRead && ID_EX_rt != 0 &&
             (ID_EX_rt == IF_ID_rs || (IF_ID_UsesRt && ID_EX_rt == IF_ID_rt));
        bl = IF_ID_Branch && EX_MEM_MemRead && EX_MEM_rd != 0 &&
             (EX_MEM_rd == IF_ID_rs || EX_MEM_rd == IF_ID_rt);
        md = (m_left > 0) && (IF_ID_MdStart || IF_ID_ReadsHiLo);
        return lu || bl || md;
    endfunction

    // Expected {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy}.
    function automatic logic [4:0] exp_outs();
        bit busy = (m_left > 0);
        if (reset)     return {4'b1100, busy};
        if (m_stall()) return {4'b0010, busy};
        return {3'b110, branch_taken, busy};
    endfunction

    task automatic model_step();
        bit st = m_stall();
        if (reset) begin
            m_left = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (IF_ID_MdStart && !st) m_left = IF_ID_MdIsDiv ? DIV_LAT : MULT_LAT;
            else if (m_left > 0)      m_left--;
            if (st && m_sc < SAT)                 m_sc++;
            if (!st && branch_taken && m_fc < SAT) m_fc++;
        end
    endtask

    // Advance one clock, keeping the model in step with the DUT.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0;
        IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_UsesRt = 0; IF_ID_Branch = 0;
        IF_ID_MdStart = 0; IF_ID_MdIsDiv = 0; IF_ID_ReadsHiLo = 0; branch_taken = 0;
        ID_EX_rt = 0; ID_EX_MemRead = 0; EX_MEM_rd = 0; EX_MEM_MemRead = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        idle_inputs();
        reset = 1;
        ID_EX_MemRead = 1; ID_EX_rt = 5; IF_ID_rs = 5; branch_taken = 1;
        #1;
        got = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outs got=%b exp=1100", got);
        end
        tick();
        checks++;
        if ({md_busy, stall_count, flush_count} !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b sc=%0d fc=%0d exp=0", md_busy, stall_count, flush_count);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        ID_EX_MemRead = 1; ID_EX_rt = 5; IF_ID_rs = 5;
        #1;
        checks++;
        if ({PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush} !== 4'b0010) begin
            errors++;
            $display("FAIL load_use_outs got=%b%b%b%b exp=0010",
                     PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_count !== 1 || PC_Write !== 1'b1) begin
            errors++;
            $display("FAIL load_use_after sc=%0d pcw=%b exp sc=1 pcw=1", stall_count, PC_Write);
        end
    endtask

    task automatic test_branch_load();
        do_reset();
        // Cycle 1: lw $5 is in EX, and beq $5,$0 is in ID.
        IF_ID_Branch = 1; IF_ID_rs = 5; IF_ID_rt = 0; branch_taken = 1;
        ID_EX_MemRead = 1; ID_EX_rt = 5;
        #1;
        checks++;
        if ({PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush} !== 4'b0010) begin
            errors++;
            $display("FAIL branch_stall1 got=%b%b%b%b exp=0010",
                     PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush);
        end
        tick();
        // Cycle 2: the load is now in MEM, and a bubble is in EX.
        ID_EX_MemRead = 0; ID_EX_rt = 0; EX_MEM_MemRead = 1; EX_MEM_rd = 5;
        #1;
        checks++;
        if ({PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush} !== 4'b0010) begin
            errors++;
            $display("FAIL branch_stall2 got=%b%b%b%b exp=0010",
                     PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush);
        end
        tick();
        // Cycle 3: the load has reached WB, so the branch resolves and flushes.
        EX_MEM_MemRead = 0; EX_MEM_rd = 0;
        #1;
        checks++;
        if ({PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush} !== 4'b1101) begin
            errors++;
            $display("FAIL branch_taken_flush got=%b%b%b%b exp=1101",
                     PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_count !== 2 || flush_count !== 1) begin
            errors++;
            $display("FAIL branch_counts sc=%0d fc=%0d exp sc=2 fc=1", stall_count, flush_count);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        ID_EX_MemRead = 1; ID_EX_rt = 0; IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_UsesRt = 1;
        #1;
        checks++;
        if (PC_Write !== 1'b1 || ID_EX_Flush !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg pcw=%b idf=%b exp pcw=1 idf=0", PC_Write, ID_EX_Flush);
        end
        ID_EX_rt = 5; IF_ID_rs = 3; IF_ID_rt = 5; IF_ID_UsesRt = 0;
        #1;
        checks++;
        if (PC_Write !== 1'b1 || ID_EX_Flush !== 1'b0) begin
            errors++;
            $display("FAIL rt_unused pcw=%b idf=%b exp pcw=1 idf=0", PC_Write, ID_EX_Flush);
        end
        idle_inputs();
    endtask

    task automatic test_mdu();
        logic [4:0] got;
        do_reset();
        IF_ID_MdStart = 1; IF_ID_MdIsDiv = 0;
        tick();
        IF_ID_MdStart = 0; IF_ID_ReadsHiLo = 1;
        for (int i = 0; i < MULT_LAT; i++) begin
            #1;
            got = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy};
            checks++;
            if (got !== 5'b00101) begin
                errors++;
                $display("FAIL mflo_stall cyc=%0d got=%b exp=00101", i, got);
            end
            tick();
        end
        got = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy};
        checks++;
        if (got !== 5'b11000 || stall_count !== MULT_LAT) begin
            errors++;
            $display("FAIL mflo_issue got=%b sc=%0d exp=11000 sc=%0d", got, stall_count, MULT_LAT);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_div_reset();
        logic [4:0] got;
        do_reset();
        IF_ID_MdStart = 1; IF_ID_MdIsDiv = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL div_busy got=%b exp=1", md_busy);
        end
        reset = 1; IF_ID_ReadsHiLo = 1; ID_EX_MemRead = 1; ID_EX_rt = 7; IF_ID_rs = 7;
        #1;
        got = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy};
        checks++;
        if (got !== 5'b11001) begin
            errors++;
            $display("FAIL div_reset_outs got=%b exp=11001", got);
        end
        tick();
        idle_inputs();
        IF_ID_MdStart = 1; IF_ID_MdIsDiv = 1;
        #1;
        got = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy};
        checks++;
        if (got !== 5'b11000 || stall_count !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL div_after_reset got=%b sc=%0d fc=%0d exp=11000 0 0",
                     got, stall_count, flush_count);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL div_reissue busy=%b exp=1", md_busy);
        end
        do_reset();
    endtask

    task automatic test_saturation();
        do_reset();
        ID_EX_MemRead = 1; ID_EX_rt = 9; IF_ID_rs = 9;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_count !== SAT[CNT_W-1:0]) begin
            errors++;
            $display("FAIL stall_saturate got=%0d exp=%0d", stall_count, SAT);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 49) == 0);
            IF_ID_rs        = 5'($urandom_range(0, 3));
            IF_ID_rt        = 5'($urandom_range(0, 3));
            IF_ID_UsesRt    = 1'($urandom);
            IF_ID_Branch    = 1'($urandom);
            branch_taken    = IF_ID_Branch & 1'($urandom);
            IF_ID_MdStart   = ($urandom_range(0, 7) == 0);
            IF_ID_MdIsDiv   = ($urandom_range(0, 3) == 0);
            IF_ID_ReadsHiLo = !IF_ID_MdStart && ($urandom_range(0, 3) == 0);
            ID_EX_rt        = 5'($urandom_range(0, 3));
            ID_EX_MemRead   = ($urandom_range(0, 2) == 0);
            EX_MEM_rd       = 5'($urandom_range(0, 3));
            EX_MEM_MemRead  = ($urandom_range(0, 2) == 0);
            #1;
            got = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_busy};
            exp = exp_outs();
            checks++;
            if (got !== exp || stall_count !== CNT_W'(m_sc) || flush_count !== CNT_W'(m_fc)) begin
                errors++;
                $display("FAIL random cyc=%0d outs=%b/%b sc=%0d/%0d fc=%0d/%0d",
                         i, got, exp, stall_count, m_sc, flush_count, m_fc);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_branch_load();
        test_no_hazard();
        test_mdu();
        test_div_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
